// File: rtl/net_generator.sv
// Centre-net video mask for the pong playfield: configurable width, dash/gap,
// phase and mode, with the pixel decision registered one clock ahead.
module net_generator #(
   parameter int H_VISIBLE = 640,
   parameter int H_TOTAL   = 800,
   parameter int WIDTH     = 8,
   parameter int DASH_LEN  = 8,
   parameter int GAP_LEN   = 8,
   parameter int Y_OFFSET  = 12
) (
   input  logic       i_Clk,
   input  logic       i_Reset_n,
   input  logic       i_HReset,
   input  logic       i_VReset,
   input  logic [1:0] i_Mode,
   output logic       o_Video
);

   localparam int PERIOD = DASH_LEN + GAP_LEN;
   localparam int CW     = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
   localparam int PW     = (PERIOD > 1) ? $clog2(PERIOD) : 1;

   localparam logic [CW-1:0] COL_LAST = CW'(H_TOTAL - 1);
   localparam logic [CW:0]   X_LEFT   = (CW+1)'(H_VISIBLE/2 - WIDTH/2);
   localparam logic [CW:0]   X_END    = (CW+1)'(H_VISIBLE/2 - WIDTH/2 + WIDTH);
   localparam logic [PW-1:0] P_LAST   = PW'(PERIOD - 1);
   localparam logic [PW-1:0] P_INIT   = PW'(Y_OFFSET % PERIOD);
   localparam logic [PW:0]   P_MOD    = (PW+1)'(PERIOD);
   localparam logic [PW:0]   P_DASH   = (PW+1)'(DASH_LEN);

   localparam logic [1:0] MODE_OFF   = 2'd0;
   localparam logic [1:0] MODE_SOLID = 2'd1;
   localparam logic [1:0] MODE_SCROLL = 2'd3;

   generate
      if (WIDTH < 1 || (WIDTH % 2) != 0) begin : g_chk_width
         $error("net_generator: WIDTH must be even and >= 1");
      end
      if (DASH_LEN < 1 || GAP_LEN < 0) begin : g_chk_dash
         $error("net_generator: DASH_LEN must be >= 1 and GAP_LEN >= 0");
      end
      if (H_VISIBLE/2 - WIDTH/2 + WIDTH > H_VISIBLE) begin : g_chk_fit
         $error("net_generator: net does not fit inside the visible line");
      end
   endgenerate

   logic [CW-1:0] r_Col;
   logic [PW-1:0] r_P;
   logic [PW-1:0] r_Scroll;
   logic [1:0]    r_Mode;
   logic          r_Armed;
   logic          r_Video;

   logic          w_Frame;
   logic [CW-1:0] w_ColNext;
   logic [PW-1:0] w_ScrollInc;
   logic [PW-1:0] w_ScrollNext;
   logic [PW-1:0] w_PInc;
   logic [PW:0]   w_PSum;
   logic [PW-1:0] w_PFrame;
   logic [PW-1:0] w_PNext;
   logic [1:0]    w_ModeNext;
   logic          w_ArmedNext;
   logic          w_XOn;
   logic          w_VOn;

   // Everything below is the state the next clock will hold, so the output flop
   // can present the decision for a column during that column's own clock.
   always_comb begin
      w_Frame = i_HReset & i_VReset;

      w_ColNext = r_Col;
      if (i_HReset)
         w_ColNext = '0;
      else if (r_Col != COL_LAST)
         w_ColNext = r_Col + 1'b1;

      w_ScrollInc  = (r_Scroll == P_LAST) ? '0 : r_Scroll + 1'b1;
      w_ScrollNext = (w_Frame && i_Mode == MODE_SCROLL) ? w_ScrollInc : r_Scroll;

      // Both operands are already below PERIOD, so one conditional subtract wraps.
      w_PSum   = {1'b0, P_INIT} + {1'b0, w_ScrollNext};
      w_PFrame = (w_PSum >= P_MOD) ? PW'(w_PSum - P_MOD) : w_PSum[PW-1:0];
      w_PInc   = (r_P == P_LAST) ? '0 : r_P + 1'b1;

      w_PNext = r_P;
      if (w_Frame)
         w_PNext = w_PFrame;
      else if (i_HReset)
         w_PNext = w_PInc;

      w_ModeNext  = w_Frame ? i_Mode : r_Mode;
      w_ArmedNext = r_Armed | w_Frame;

      w_XOn = ({1'b0, w_ColNext} >= X_LEFT) && ({1'b0, w_ColNext} < X_END);

      case (w_ModeNext)
         MODE_OFF:   w_VOn = 1'b0;
         MODE_SOLID: w_VOn = 1'b1;
         default:    w_VOn = ({1'b0, w_PNext} < P_DASH);
      endcase
   end

   always_ff @(posedge i_Clk or negedge i_Reset_n) begin
      if (!i_Reset_n) begin
         r_Col    <= '0;
         r_P      <= P_INIT;
         r_Scroll <= '0;
         r_Mode   <= MODE_OFF;
         r_Armed  <= 1'b0;
         r_Video  <= 1'b0;
      end else begin
         r_Col    <= w_ColNext;
         r_P      <= w_PNext;
         r_Scroll <= w_ScrollNext;
         r_Mode   <= w_ModeNext;
         r_Armed  <= w_ArmedNext;
         r_Video  <= w_ArmedNext & w_XOn & w_VOn;
      end
   end

   assign o_Video = r_Video;

endmodule

// File: tb/tb_net_generator.sv
// Randomised bench for net_generator: three parameter sets share one stimulus
// stream; a line/frame-level model feeds a scoreboard checked by a monitor.
module tb_net_generator;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       hres = 1'b0;
   logic       vres = 1'b0;
   logic [1:0] mode = 2'd0;
   logic [2:0] vid;

   net_generator u_dut0 (
      .i_Clk(clk), .i_Reset_n(rst_n), .i_HReset(hres), .i_VReset(vres),
      .i_Mode(mode), .o_Video(vid[0])
   );

   net_generator #(.WIDTH(4), .DASH_LEN(3), .GAP_LEN(5), .Y_OFFSET(0)) u_dut1 (
      .i_Clk(clk), .i_Reset_n(rst_n), .i_HReset(hres), .i_VReset(vres),
      .i_Mode(mode), .o_Video(vid[1])
   );

   net_generator #(.GAP_LEN(0)) u_dut2 (
      .i_Clk(clk), .i_Reset_n(rst_n), .i_HReset(hres), .i_VReset(vres),
      .i_Mode(mode), .o_Video(vid[2])
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0] v;
      int         col;
      int         line;
   } exp_t;

   exp_t sb[$];
   int   n_chk = 0;
   int   n_err = 0;
   bit   drive_rst = 1'b0;

   // Model state in screen terms: pixel column, line within frame, frames scrolled.
   int   m_col = 0;
   int   m_line = 0;
   int   m_mode = 0;
   int   m_scroll = 0;
   bit   m_armed = 1'b0;

   function automatic bit exp_bit(input int k);
      int w, d, g, y, per, xl;
      bit von;
      case (k)
         0:       begin w = 8; d = 8; g = 8; y = 12; end
         1:       begin w = 4; d = 3; g = 5; y = 0;  end
         default: begin w = 8; d = 8; g = 0; y = 12; end
      endcase
      per = d + g;
      xl  = 320 - w / 2;
      if (m_mode == 1)      von = 1'b1;
      else if (m_mode >= 2) von = ((y + m_scroll + m_line) % per) < d;
      else                  von = 1'b0;
      return m_armed && (m_col >= xl) && (m_col < xl + w) && von;
   endfunction

   task automatic model_reset();
      m_col = 0; m_line = 0; m_mode = 0; m_scroll = 0; m_armed = 1'b0;
   endtask

   task automatic step(input bit h, input bit v, input logic [1:0] m);
      exp_t e;
      @(negedge clk);
      rst_n = drive_rst;
      hres = h; vres = v; mode = m;
      if (!rst_n) model_reset();
      else if (h && v) begin
         m_mode = int'(m);
         if (m == 2'd3) m_scroll++;
         m_armed = 1'b1; m_line = 0; m_col = 0;
      end else if (h) begin
         m_line++; m_col = 0;
      end else if (m_col < 799) m_col++;
      e.v = {exp_bit(2), exp_bit(1), exp_bit(0)};
      e.col = m_col;
      e.line = m_line;
      sb.push_back(e);
   endtask

   function automatic int rl();
      return int'($urandom_range(326, 340));
   endfunction

   function automatic logic [1:0] rm();
      return 2'($urandom_range(0, 3));
   endfunction

   task automatic line(input int len, input bit last_v, input logic [1:0] last_m);
      for (int i = 0; i < len - 1; i++) step(1'b0, ($urandom_range(0, 7) == 0), rm());
      step(1'b1, last_v, last_m);
   endtask

   task automatic frame(input int n, input logic [1:0] next_m);
      for (int i = 0; i < n - 1; i++) line(rl(), 1'b0, rm());
      line(rl(), 1'b1, next_m);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            for (int k = 0; k < 3; k++) begin
               n_chk++;
               if (vid[k] !== e.v[k]) begin
                  n_err++;
                  $display("FAIL video dut%0d col=%0d line=%0d got=%b exp=%b",
                           k, e.col, e.line, vid[k], e.v[k]);
               end
            end
         end
      end
   end

   initial begin : stim
      int guard;
      repeat (3) @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         n_chk++;
         if (vid[k] !== 1'b0) begin
            n_err++;
            $display("FAIL reset dut%0d got=%b exp=0", k, vid[k]);
         end
      end
      drive_rst = 1'b1;

      // Unarmed lines, then the first frame boundary in dashed mode.
      line(rl(), 1'b0, rm());
      line(rl(), 1'b0, rm());
      line(rl(), 1'b1, 2'd2);
      frame(20, 2'd1);          // dashed frame, next solid
      frame(10, 2'd0);          // solid, mid-frame mode noise, next off
      frame(4, 2'd3);           // off, next scrolling
      for (int f = 0; f < 16; f++) frame((f < 3) ? 18 : 3, (f == 15) ? 2'd1 : 2'd3);

      // Solid frame: asynchronous reset while inside the net columns.
      for (int i = 0; i < 5; i++) line(rl(), 1'b0, rm());
      guard = 0;
      while (m_col != 319 && guard < 400) begin
         step(1'b0, 1'b0, rm());
         guard++;
      end
      n_chk++;
      if (m_col != 319) begin
         n_err++;
         $display("FAIL reach_col got=%0d exp=319", m_col);
      end
      @(negedge clk);
      rst_n = 1'b0;
      drive_rst = 1'b0;
      model_reset();
      #1;
      for (int k = 0; k < 3; k++) begin
         n_chk++;
         if (vid[k] !== 1'b0) begin
            n_err++;
            $display("FAIL async_rst dut%0d got=%b exp=0", k, vid[k]);
         end
      end
      for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 2'd1);
      drive_rst = 1'b1;
      line(rl(), 1'b0, rm());
      line(rl(), 1'b0, rm());
      line(rl(), 1'b1, 2'd2);
      frame(4, rm());

      for (int f = 0; f < 4; f++) frame(6, rm());

      // Withheld line pulse: column saturates, then a normal line follows.
      line(1100, 1'b0, rm());
      line(800, 1'b0, rm());
      line(rl(), 1'b0, rm());

      @(posedge clk);
      #2;
      n_chk++;
      if (sb.size() != 0) begin
         n_err++;
         $display("FAIL drain pending=%0d exp=0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/net_generator.md
# net_generator

Parametrised centre-net generator for the pong playfield, producing a single-bit video mask for the vertical net. It extends the fixed 8-pixel, 8-on/8-off net with configurable width, dash/gap lengths, vertical offset, a runtime mode (off, solid, dashed, scrolling dashed) and a registered, glitch-free output. It sits beside the paddle and ball drawers and is OR-ed into the video mux, driven by the shared sync counter's line/frame reset pulses.

## Interface
- H_VISIBLE, 640: visible pixels per line; the net is centred on H_VISIBLE/2.
- H_TOTAL, 800: total clocks per line; sizes the column counter.
- WIDTH, 8: net width in pixels, ≥1, even.
- DASH_LEN, 8: lines per dash, ≥1.
- GAP_LEN, 8: lines per gap, ≥0. A value of 0 makes the dashed modes render solid.
- Y_OFFSET, 12: initial pattern phase in lines, taken mod PERIOD. PERIOD = DASH_LEN + GAP_LEN.

Ports (name, direction, width, meaning):
- i_Clk, in, 1: pixel clock. Everything is on the rising edge.
- i_Reset_n, in, 1: asynchronous, active-low reset.
- i_HReset, in, 1: one-cycle pulse on the last clock of each line.
- i_VReset, in, 1: qualifies i_HReset. When both are high, the next line is line 0 of a new frame.
- i_Mode, in, 2: 0 = off, 1 = solid, 2 = dashed, 3 = scrolling dashed. Sampled only at a frame boundary.
- o_Video, out, 1: registered net mask for the current pixel.

## Operation
- **Column definition.** Column c is the number of clocks since the last i_HReset cycle, minus 1. The clock after i_HReset is column 0.
- **Line definition.** Line L is the count of i_HReset pulses since the last frame boundary.
- **Column counter.** Width clog2(H_TOTAL). Cleared by i_HReset. Saturates at H_TOTAL-1 if i_HReset is missing; it does not wrap.
- **Pattern counter p.** Width clog2(PERIOD).
  - Each i_HReset: p ← (p+1) mod PERIOD.
  - Frame boundary: p ← (Y_OFFSET + scroll) mod PERIOD, using the scroll value that is being committed on that same boundary.
- **Scroll counter.** Width clog2(PERIOD). Updated only at a frame boundary.
  - If the newly latched mode is 3: scroll ← (scroll+1) mod PERIOD.
  - Otherwise it holds.
  - The first frame after entering mode 3 is already shifted by 1.
- **Mode register.** Loads i_Mode at each frame boundary. Mode changes mid-frame have no effect until the next boundary.
- **Armed flag.**
  - Cleared by reset; set at the first frame boundary.
  - While clear, o_Video = 0 regardless of mode. This avoids a partial net on the first, unsynchronised frame.
- **Horizontal condition.** X_LEFT = H_VISIBLE/2 − WIDTH/2; X_ON ⇔ X_LEFT ≤ c < X_LEFT + WIDTH.
- **Vertical condition by mode.** Mode 0: never. Mode 1: always. Modes 2/3: p < DASH_LEN.
- **Output.** o_Video = armed ∧ X_ON ∧ vertical condition. It is zero outside these columns, including during blanking.
- **Simultaneous events.** i_VReset without i_HReset is ignored. i_HReset together with i_VReset is a frame boundary, and it takes precedence over the line increment.

## Timing
- **Reset values.** o_Video = 0, column = 0, p = Y_OFFSET mod PERIOD, scroll = 0, mode = 0, armed = 0.
- **Latency.** o_Video is a flop, so the decision is made one clock ahead (look-ahead compare on column+1 / next p). The observed output for column c is valid during exactly that column's clock. There is no extra pipeline delay visible at the port.
- **Line-start pixel.** The output during the i_HReset cycle itself belongs to column H_TOTAL−1 and is therefore 0.
- **Reset mid-frame.** All state returns to reset values immediately (asynchronous). o_Video stays 0 until the next frame boundary.
- **Width rule.** The column compare uses unsigned arithmetic of counter width. X_LEFT + WIDTH ≤ H_VISIBLE is a legal-parameter requirement, enforced by an elaboration-time check.

## Test plan
- **Legacy equivalence.** Defaults, mode 2, 640×480 stimulus with H_TOTAL = 800 → o_Video high for columns 316–323 on lines L where L mod 16 ∈ 4..11, zero elsewhere.
- **Solid/off.** Mode 1 → columns 316–323 high on every line 0–479. Switch to mode 0 mid-frame → the current frame is unchanged; the next frame is all zero.
- **Scrolling.** Mode 3 for 3 frames → the dash start line moves from 3 to 2 to 1 (lines L with (L+12+s) mod 16 < 8, s = 1, 2, 3). After 16 frames in mode 3, scroll wraps to 0.
- **Parameter sweep.** WIDTH = 4, DASH_LEN = 3, GAP_LEN = 5, Y_OFFSET = 0 → columns 318–321, lines with L mod 8 ∈ {0, 1, 2}. GAP_LEN = 0 → solid in mode 2.
- **Reset/arming.** Assert i_Reset_n low for 5 clocks mid-line inside the net columns → o_Video drops to 0 asynchronously. It stays 0 through the remainder of the frame and resumes only after the next i_HReset ∧ i_VReset.
- **Missing HReset.** Withhold i_HReset for 1000 clocks → the column counter saturates at 799 and o_Video stays 0. A normal line follows after the next pulse.
